port_wr_frontend: RTL

- Per-port ingress front end. Sits directly upstream of the port's SRAM matcher.
- Accepts a 16-bit packet stream and decodes the header word. It drives new_length, match_enable and dest_port toward the matcher.
- Buffers payload while matching runs, then streams the packet to the SRAM returned in match_best_sram.
- Drops the packet if no SRAM is granted within a timeout.

---
 rtl/port_wr_frontend.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/port_wr_frontend.sv
// Per-port ingress front end: decodes the packet header, requests an SRAM match,
// buffers payload while matching runs, then streams it to the granted SRAM or drops it.
module port_wr_frontend #(
   parameter int FIFO_DEPTH    = 64,
   parameter int MATCH_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_sop,
   input  logic        wr_eop,
   input  logic        wr_vld,
   input  logic [15:0] wr_data,
   output logic        wr_ready,
   output logic [5:0]  new_length,
   output logic [3:0]  dest_port,
   output logic        match_enable,
   input  logic        match_suc,
   input  logic [5:0]  match_best_sram,
   output logic        sram_wr_en,
   output logic [4:0]  sram_wr_sel,
   output logic        sram_wr_sop,
   output logic        sram_wr_eop,
   output logic [15:0] sram_wr_data,
   output logic [15:0] drop_cnt
);

   // state  | meaning
   // IDLE   | waiting for a header word (wr_sop)
   // MATCH  | match_enable high, payload buffered, waiting for grant or timeout
   // XFER   | streaming buffered payload to the granted SRAM
   // DROP   | discarding the rest of the packet, FIFO flushed

   localparam int             AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [7:0]     TMO_LAST = 8'(MATCH_TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_MATCH, S_XFER, S_DROP} state_t;

   state_t         state_q;
   logic [16:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0]  wptr_q, rptr_q;
   logic [AW:0]    cnt_q;
   logic           eop_seen_q, first_q;
   logic [7:0]     tmo_q;
   logic [5:0]     new_length_q;
   logic [3:0]     dest_port_q;
   logic           match_enable_q;
   logic           sram_wr_en_q, sram_wr_sop_q, sram_wr_eop_q;
   logic [4:0]     sram_wr_sel_q;
   logic [15:0]    sram_wr_data_q;
   logic [15:0]    drop_cnt_q;

   logic fifo_full, fifo_empty, accept, push, pop;
   logic grant_ok, grant_none, timeout, to_drop;
   logic [16:0] pop_word;

   assign fifo_full  = (cnt_q == FULL_CNT);
   assign fifo_empty = (cnt_q == '0);

   always_comb begin
      wr_ready = 1'b1;
      if (state_q == S_MATCH || state_q == S_XFER)
         wr_ready = ~fifo_full & ~eop_seen_q;
   end

   assign accept     = wr_vld & wr_ready;
   assign push       = accept & ((state_q == S_MATCH) | (state_q == S_XFER));
   assign pop        = (state_q == S_XFER) & ~fifo_empty;
   assign pop_word   = mem_q[rptr_q];
   // index 32 (bit 5 set) means the matcher found no SRAM
   assign grant_ok   = match_suc & ~match_best_sram[5];
   assign grant_none = match_suc &  match_best_sram[5];
   assign timeout    = (tmo_q == TMO_LAST);
   assign to_drop    = (state_q == S_MATCH) & ~grant_ok & (grant_none | timeout);

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= {wr_eop, wr_data};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         wptr_q         <= '0;
         rptr_q         <= '0;
         cnt_q          <= '0;
         eop_seen_q     <= 1'b0;
         first_q        <= 1'b0;
         tmo_q          <= '0;
         new_length_q   <= '0;
         dest_port_q    <= '0;
         match_enable_q <= 1'b0;
         sram_wr_en_q   <= 1'b0;
         sram_wr_sop_q  <= 1'b0;
         sram_wr_eop_q  <= 1'b0;
         sram_wr_sel_q  <= '0;
         sram_wr_data_q <= '0;
         drop_cnt_q     <= '0;
      end else begin
         if (to_drop) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
         end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (push & ~pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop & ~push) cnt_q <= cnt_q - 1'b1;
         end

         sram_wr_en_q  <= 1'b0;
         sram_wr_sop_q <= 1'b0;
         sram_wr_eop_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               // header-only packets never reach the matcher
               if (accept & wr_sop & ~wr_eop) begin
                  new_length_q   <= wr_data[15:10];
                  dest_port_q    <= wr_data[3:0];
                  match_enable_q <= 1'b1;
                  tmo_q          <= '0;
                  eop_seen_q     <= 1'b0;
                  state_q        <= S_MATCH;
               end
            end
            S_MATCH: begin
               tmo_q <= tmo_q + 8'd1;
               if (accept & wr_eop) eop_seen_q <= 1'b1;
               if (grant_ok) begin
                  sram_wr_sel_q  <= match_best_sram[4:0];
                  match_enable_q <= 1'b0;
                  first_q        <= 1'b1;
                  state_q        <= S_XFER;
               end else if (to_drop) begin
                  match_enable_q <= 1'b0;
                  if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
                  state_q        <= S_DROP;
               end
            end
            S_XFER: begin
               if (accept & wr_eop) eop_seen_q <= 1'b1;
               if (pop) begin
                  sram_wr_en_q   <= 1'b1;
                  sram_wr_data_q <= pop_word[15:0];
                  sram_wr_sop_q  <= first_q;
                  sram_wr_eop_q  <= pop_word[16];
                  first_q        <= 1'b0;
                  if (pop_word[16]) begin
                     eop_seen_q <= 1'b0;
                     state_q    <= S_IDLE;
                  end
               end
            end
            S_DROP: begin
               if (eop_seen_q | (accept & wr_eop)) begin
                  eop_seen_q <= 1'b0;
                  state_q    <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign new_length   = new_length_q;
   assign dest_port    = dest_port_q;
   assign match_enable = match_enable_q;
   assign sram_wr_en   = sram_wr_en_q;
   assign sram_wr_sel  = sram_wr_sel_q;
   assign sram_wr_sop  = sram_wr_sop_q;
   assign sram_wr_eop  = sram_wr_eop_q;
   assign sram_wr_data = sram_wr_data_q;
   assign drop_cnt     = drop_cnt_q;

endmodule
